// File: rtl/rtf65002_pkg.sv
// rtf65002 multiply/divide shared encodings.
// Divider datapath is built only with RTF65002_DIVMOD_EN defined.
package rtf65002_pkg;

  typedef enum logic [1:0] {
    MD_MULU = 2'd0,
    MD_MULS = 2'd1,
    MD_DIVU = 2'd2,
    MD_DIVS = 2'd3
  } md_op_e;

  typedef enum logic [2:0] {
    MD_IDLE,
    MD_MUL,
    MD_DIV,
    MD_FIX,
    MD_DONE
  } md_state_e;

endpackage

// File: rtl/rtf65002_cond_neg.sv
// Conditional two's-complement negate: y = neg ? -x : x.
// Used for operand magnitudes and result sign correction.
module rtf65002_cond_neg #(
  parameter int W = 32
) (
  input  logic [W-1:0] x,
  input  logic         neg,
  output logic [W-1:0] y
);

  assign y = neg ? (~x + W'(1)) : x;

endmodule

// File: rtl/rtf65002_muldiv.sv
// rtf65002 sequential multiply/divide unit, one result bit per clock.
// Optional MOD/DIV support: define RTF65002_DIVMOD_EN.
module rtf65002_muldiv
  import rtf65002_pkg::*;
#(
  parameter int WID = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ld,
  input  logic [1:0]       op,
  input  logic [WID-1:0]   a,
  input  logic [WID-1:0]   b,
  output logic [2*WID-1:0] prod,
  output logic             busy,
  output logic             done,
  output logic             dbz
);

  localparam int CW = $clog2(WID + 1);

  md_state_e      state;
  logic [WID-1:0] acc;
  logic [WID-1:0] lo;
  logic [WID-1:0] dvs;
  logic [WID-1:0] abs_a;
  logic [WID-1:0] abs_b;
  logic [WID-1:0] madd;
  logic [WID:0]   msum;
  logic [2*WID-1:0] p_fix;
  logic [CW-1:0]  cnt;
  logic           sa;
  logic           sb;
  logic           sgn;
  logic           is_div;
  logic           accept;
  logic           last;

  assign sgn    = (op == MD_MULS) || (op == MD_DIVS);
  assign is_div = (op == MD_DIVU) || (op == MD_DIVS);
  assign accept = ld && (state == MD_IDLE || state == MD_DONE);
  assign last   = (cnt == CW'(1));
  assign madd   = lo[0] ? dvs : '0;
  assign msum   = {1'b0, acc} + {1'b0, madd};

  rtf65002_cond_neg #(.W(WID)) u_abs_a (
    .x   (a),
    .neg (sgn & a[WID-1]),
    .y   (abs_a)
  );

  rtf65002_cond_neg #(.W(WID)) u_abs_b (
    .x   (b),
    .neg (sgn & b[WID-1]),
    .y   (abs_b)
  );

  rtf65002_cond_neg #(.W(2*WID)) u_fix_p (
    .x   ({acc, lo}),
    .neg (sa ^ sb),
    .y   (p_fix)
  );

`ifdef RTF65002_DIVMOD_EN
  logic           div_r;
  logic           ge;
  logic [WID:0]   rsh;
  logic [WID-1:0] rdif;
  logic [WID-1:0] q_fix;
  logic [WID-1:0] r_fix;

  // Partial remainder stays below the divisor, so WID bits hold the difference.
  assign rsh  = {acc, lo[WID-1]};
  assign ge   = rsh >= {1'b0, dvs};
  assign rdif = rsh[WID-1:0] - dvs;

  rtf65002_cond_neg #(.W(WID)) u_fix_q (
    .x   (lo),
    .neg (sa ^ sb),
    .y   (q_fix)
  );

  rtf65002_cond_neg #(.W(WID)) u_fix_r (
    .x   (acc),
    .neg (sa),
    .y   (r_fix)
  );
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= MD_IDLE;
      acc   <= '0;
      lo    <= '0;
      dvs   <= '0;
      cnt   <= '0;
      sa    <= 1'b0;
      sb    <= 1'b0;
      prod  <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      dbz   <= 1'b0;
`ifdef RTF65002_DIVMOD_EN
      div_r <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      unique case (state)
        MD_MUL: begin
          acc <= msum[WID:1];
          lo  <= {msum[0], lo[WID-1:1]};
          cnt <= cnt - CW'(1);
          if (last) state <= MD_FIX;
        end
`ifdef RTF65002_DIVMOD_EN
        MD_DIV: begin
          acc <= ge ? rdif : rsh[WID-1:0];
          lo  <= {lo[WID-2:0], ge};
          cnt <= cnt - CW'(1);
          if (last) state <= MD_FIX;
        end
`endif
        MD_FIX: begin
`ifdef RTF65002_DIVMOD_EN
          prod <= div_r ? {r_fix, q_fix} : p_fix;
`else
          prod <= p_fix;
`endif
          state <= MD_DONE;
        end
        MD_DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= MD_IDLE;
        end
        default: state <= MD_IDLE;
      endcase

      if (accept) begin
        sa   <= sgn & a[WID-1];
        sb   <= sgn & b[WID-1];
        dvs  <= abs_b;
        acc  <= '0;
        lo   <= abs_a;
        cnt  <= CW'(WID);
        busy <= 1'b1;
        dbz  <= 1'b0;
        if (!is_div) begin
          state <= MD_MUL;
`ifdef RTF65002_DIVMOD_EN
          div_r <= 1'b0;
        end else if (b == '0) begin
          // Quotient all ones, remainder raw dividend, no sign fix.
          div_r <= 1'b1;
          sa    <= 1'b0;
          sb    <= 1'b0;
          acc   <= a;
          lo    <= '1;
          dbz   <= 1'b1;
          state <= MD_FIX;
        end else begin
          div_r <= 1'b1;
          state <= MD_DIV;
        end
`else
        end else begin
          prod  <= '0;
          state <= MD_DONE;
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_rtf65002_muldiv.sv
// Self-checking bench for rtf65002_muldiv against an arithmetic model.
// Expectations follow RTF65002_DIVMOD_EN when it is defined.
module tb_rtf65002_muldiv;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ld = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [63:0] prod;
  logic        busy;
  logic        done;
  logic        dbz;

  int errors = 0;
  int checks = 0;

  rtf65002_muldiv #(.WID(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ld    (ld),
    .op    (op),
    .a     (a),
    .b     (b),
    .prod  (prod),
    .busy  (busy),
    .done  (done),
    .dbz   (dbz)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic; SV division truncates toward zero.
  function automatic void model(input logic [1:0] o, input logic [31:0] x,
                                input logic [31:0] y, output logic [63:0] p,
                                output logic z, output int lat);
    longint sx, sy, q, r;
    z   = 1'b0;
    lat = 34;
    sx  = longint'($signed(x));
    sy  = longint'($signed(y));
    q   = 0;
    r   = 0;
    case (o)
      2'd0: p = {32'h0, x} * {32'h0, y};
      2'd1: p = 64'(sx * sy);
      default: begin
`ifdef RTF65002_DIVMOD_EN
        if (y == 32'h0) begin
          p   = {x, 32'hFFFF_FFFF};
          z   = 1'b1;
          lat = 2;
        end else if (o == 2'd2) begin
          p = {x % y, x / y};
        end else begin
          q = sx / sy;
          r = sx % sy;
          p = {r[31:0], q[31:0]};
        end
`else
        p   = 64'h0;
        lat = 1;
`endif
      end
    endcase
  endfunction

  task automatic issue(input logic [1:0] o, input logic [31:0] x,
                       input logic [31:0] y);
    @(negedge clk);
    op = o;
    a  = x;
    b  = y;
    ld = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Entered #1 after the accepting edge; returns #1 after the done edge.
  task automatic await(input string tag, input logic [1:0] o,
                       input logic [31:0] x, input logic [31:0] y,
                       input bit idle_after);
    logic [63:0] ep;
    logic        ez;
    int          lat;
    int          n;
    bit          busy_ok;
    model(o, x, y, ep, ez, lat);
    n = 0;
    busy_ok = (busy === 1'b1);
    while (n < 100) begin
      @(posedge clk);
      n++;
      #1;
      if (done === 1'b1) break;
      if (busy !== 1'b1) busy_ok = 1'b0;
    end
    chk({tag, "_lat"}, 64'(n), 64'(lat));
    chk({tag, "_busy"}, 64'(busy_ok), 64'd1);
    chk({tag, "_prod"}, prod, ep);
    chk({tag, "_dbz"}, 64'(dbz), 64'(ez));
    if (idle_after) chk({tag, "_idle"}, 64'(busy), 64'd0);
  endtask

  initial begin
    logic [1:0]  ro;
    logic [31:0] rx;
    logic [31:0] ry;
    int          dn;

    #2;
    chk("rst_prod", prod, 64'h0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_dbz", 64'(dbz), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    issue(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    ld = 1'b0;
    await("mulu_max", 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    chk("mulu_max_c", prod, 64'hFFFF_FFFE_0000_0001);

    issue(2'd1, 32'hFFFF_FFFD, 32'd7);
    ld = 1'b0;
    await("muls_neg", 2'd1, 32'hFFFF_FFFD, 32'd7, 1'b1);
    chk("muls_neg_c", prod, 64'hFFFF_FFFF_FFFF_FFEB);

    issue(2'd2, 32'd100, 32'd7);
    ld = 1'b0;
    await("divu", 2'd2, 32'd100, 32'd7, 1'b1);

    issue(2'd3, 32'hFFFF_FFF9, 32'd2);
    ld = 1'b0;
    await("divs_neg", 2'd3, 32'hFFFF_FFF9, 32'd2, 1'b1);

    issue(2'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    ld = 1'b0;
    await("divs_ovf", 2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
`ifdef RTF65002_DIVMOD_EN
    chk("divs_ovf_c", prod, 64'h0000_0000_8000_0000);
`endif

    issue(2'd2, 32'd5, 32'd0);
    ld = 1'b0;
    await("divu_dbz", 2'd2, 32'd5, 32'd0, 1'b1);

    // ld stays high: ignored while busy, accepted again in the DONE cycle.
    issue(2'd2, 32'd100, 32'd7);
    op = 2'd0;
    a  = 32'd3;
    b  = 32'd4;
    await("hold", 2'd2, 32'd100, 32'd7, 1'b0);
    ld = 1'b0;
    chk("b2b_busy", 64'(busy), 64'd1);
    await("b2b", 2'd0, 32'd3, 32'd4, 1'b1);

    for (int i = 0; i < 20; i++) begin
      ro = 2'($urandom_range(0, 3));
      rx = $urandom;
      ry = $urandom;
      if (i % 5 == 1) ry = 32'($urandom_range(1, 15));
      if (i % 7 == 3) ry = 32'h0;
      issue(ro, rx, ry);
      ld = 1'b0;
      await($sformatf("rnd%0d", i), ro, rx, ry, 1'b1);
    end

    issue(2'd0, 32'h1234_5678, 32'h9ABC_DEF0);
    ld = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_prod", prod, 64'h0);
    chk("abort_busy", 64'(busy), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    dn = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) dn++;
    end
    chk("abort_nodone", 64'(dn), 64'd0);

    issue(2'd0, 32'd3, 32'd4);
    ld = 1'b0;
    await("post_rst", 2'd0, 32'd3, 32'd4, 1'b1);
    chk("post_rst_c", prod, 64'd12);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
